// File: rtl/pc_sequencer.sv
// Program counter and control-flow unit: sequential fetch, Z/C relative branches, jumps and
// call/return through a hardware return-address stack. Define PCSEQ_TRAP_EN to vector stack errors.
module pc_sequencer #(
  parameter int unsigned PC_W  = 12,
  parameter int unsigned OFF_W = 8,
  parameter int unsigned DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(12'hFF0),
  localparam int unsigned SpW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [2:0]       cmd_i,
  input  logic [1:0]       cond_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [PC_W-1:0]  tgt_i,
  input  logic             z_i,
  input  logic             c_i,
  input  logic             clr_err_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             taken_o,
  output logic [SpW-1:0]   sp_level_o,
  output logic             stk_full_o,
  output logic             stk_empty_o,
  output logic             ovf_o,
  output logic             unf_o,
  output logic             trap_o
);

  localparam logic [2:0] CmdBr   = 3'd1;
  localparam logic [2:0] CmdJmp  = 3'd2;
  localparam logic [2:0] CmdCall = 3'd3;
  localparam logic [2:0] CmdRet  = 3'd4;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [SpW-1:0]  sp_q, sp_d;
  logic            taken_q, taken_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            trap_d;
  logic            push;
  logic [PC_W-1:0] stack_q [DEPTH];

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] br_pc;
  logic [PC_W-1:0] top_entry;
  logic            cond_true;
  logic            full;
  logic            empty;

  assign seq_pc  = pc_q + PC_W'(1);
  // Sign-extend the offset to the PC width; the add then wraps modulo 2^PC_W.
  assign off_ext = PC_W'($signed(off_i));
  assign br_pc   = seq_pc + off_ext;
  assign full    = (sp_q == SpW'(DEPTH));
  assign empty   = (sp_q == '0);

  always_comb begin
    cond_true = 1'b0;
    unique case (cond_i)
      2'b00: cond_true = z_i;
      2'b01: cond_true = ~z_i;
      2'b10: cond_true = c_i;
      2'b11: cond_true = ~c_i;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    top_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SpW'(i + 1)) top_entry = stack_q[i];
    end
  end

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    taken_d = 1'b0;
    trap_d  = 1'b0;
    push    = 1'b0;
    ovf_d   = ovf_q & ~clr_err_i;
    unf_d   = unf_q & ~clr_err_i;
    if (en_i) begin
      pc_d = seq_pc;
      case (cmd_i)
        CmdBr: begin
          if (cond_true) begin
            pc_d    = br_pc;
            taken_d = 1'b1;
          end
        end
        CmdJmp: begin
          pc_d    = tgt_i;
          taken_d = 1'b1;
        end
        CmdCall: begin
          taken_d = 1'b1;
          if (full) begin
            ovf_d = 1'b1;
`ifdef PCSEQ_TRAP_EN
            pc_d   = TRAP_VEC;
            trap_d = 1'b1;
`else
            pc_d   = tgt_i;
`endif
          end else begin
            push = 1'b1;
            sp_d = sp_q + SpW'(1);
            pc_d = tgt_i;
          end
        end
        CmdRet: begin
          if (empty) begin
            unf_d = 1'b1;
`ifdef PCSEQ_TRAP_EN
            pc_d    = TRAP_VEC;
            taken_d = 1'b1;
            trap_d  = 1'b1;
`endif
          end else begin
            pc_d    = top_entry;
            sp_d    = sp_q - SpW'(1);
            taken_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_VEC;
      sp_q    <= '0;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      taken_q <= taken_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage needs no reset; only entries below sp_q are ever read.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && !rst_i && (sp_q == SpW'(i))) stack_q[i] <= seq_pc;
    end
  end

`ifdef PCSEQ_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) trap_q <= 1'b0;
    else       trap_q <= trap_d;
  end
  assign trap_o = trap_q;
`else
  assign trap_o = 1'b0;
`endif

  assign pc_o        = pc_q;
  assign taken_o     = taken_q;
  assign sp_level_o  = sp_q;
  assign stk_full_o  = full;
  assign stk_empty_o = empty;
  assign ovf_o       = ovf_q;
  assign unf_o       = unf_q;

endmodule
